// File: rtl/rat_pipe_pkg.sv
// Shared pipeline types for the RAT MCU stage RTL: hazard FSM states,
// forwarding source select, statistics counter width and a mask helper.
package rat_pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hazard_state_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_EX = 2'd1,
        FWD_WB = 2'd2
    } fwd_src_t;

    localparam int STATS_W = 16;

    // Mask with the n lowest bits set (n = 0..4). Used for the squash
    // pattern while a flush drains: only slots still holding wrong-path
    // instructions are cleared.
    function automatic logic [3:0] low_mask(input logic [2:0] n);
        logic [3:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(n)) m[k] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/rat_fwd_port.sv
// One decode read port: compares the read address against the execute and
// writeback destinations, selects the freshest operand and flags a
// load-use conflict that forwarding cannot resolve.
module rat_fwd_port
    import rat_pipe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_use,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_wr_en,
    input  logic [ADDR_W-1:0] ex_wr_addr,
    input  logic              ex_wr_load,
    input  logic [DATA_W-1:0] ex_wr_data,
    input  logic              wb_wr_en,
    input  logic [ADDR_W-1:0] wb_wr_addr,
    input  logic [DATA_W-1:0] wb_wr_data,
    output logic [DATA_W-1:0] fwd_data,
    output logic              load_hit
);

    fwd_src_t src;
    logic     ex_match;

    assign ex_match = ex_wr_en && (ex_wr_addr == rd_addr);

    // Source select: execute is the younger producer and wins over writeback;
    // a load in execute has no data yet, so it never forwards.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        src = FWD_RF;
        if (ex_match && !ex_wr_load) begin
            src = FWD_EX;
        end else if (wb_wr_en && (wb_wr_addr == rd_addr)) begin
            src = FWD_WB;
        end
    end

    // Operand mux driven by the selected source.
    always_comb begin
        fwd_data = rf_data;
        case (src)
            FWD_EX:  fwd_data = ex_wr_data;
            FWD_WB:  fwd_data = wb_wr_data;
            default: fwd_data = rf_data;
        endcase
    end

    assign load_hit = rd_use && ex_match && ex_wr_load;

endmodule

// File: rtl/rat_hazard_ctrl.sv
// Hazard/forwarding controller for the pipelined RAT MCU. Forwards operands
// to N_RD decode read ports, interlocks load-use with a one-cycle stall and
// squashes FLUSH_DEPTH younger slots after a taken branch.
// Optional stall/flush statistics counters: define RAT_HAZARD_STATS_EN.
module rat_hazard_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int N_RD        = 2,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [N_RD*ADDR_W-1:0]   DEC_RD_ADDR,
    input  logic [N_RD-1:0]          DEC_RD_USE,
    input  logic [N_RD*DATA_W-1:0]   RF_RD_DATA,
    input  logic                     EX_WR_EN,
    input  logic [ADDR_W-1:0]        EX_WR_ADDR,
    input  logic                     EX_WR_LOAD,
    input  logic [DATA_W-1:0]        EX_WR_DATA,
    input  logic                     WB_WR_EN,
    input  logic [ADDR_W-1:0]        WB_WR_ADDR,
    input  logic [DATA_W-1:0]        WB_WR_DATA,
    input  logic                     BRN_TAKEN,
    output logic [N_RD*DATA_W-1:0]   FWD_RD_DATA,
    output logic                     STALL,
    output logic                     BUBBLE_EX,
    output logic [FLUSH_DEPTH-1:0]   SQUASH,
    output logic [15:0]              STALL_CNT,
    output logic [15:0]              FLUSH_CNT
);

    rat_pipe_pkg::hazard_state_t state, state_nx;
    logic [2:0]             cnt, cnt_nx;
    logic [N_RD-1:0]        load_hit;
    logic                   hazard;
    logic                   stall_c, bubble_c;
    logic [FLUSH_DEPTH-1:0] squash_c;
    logic [3:0]             mask_w;

    for (genvar i = 0; i < N_RD; i++) begin : g_port
        rat_fwd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_port (
            .rd_addr    (DEC_RD_ADDR[i*ADDR_W +: ADDR_W]),
            .rd_use     (DEC_RD_USE[i]),
            .rf_data    (RF_RD_DATA[i*DATA_W +: DATA_W]),
            .ex_wr_en   (EX_WR_EN),
            .ex_wr_addr (EX_WR_ADDR),
            .ex_wr_load (EX_WR_LOAD),
            .ex_wr_data (EX_WR_DATA),
            .wb_wr_en   (WB_WR_EN),
            .wb_wr_addr (WB_WR_ADDR),
            .wb_wr_data (WB_WR_DATA),
            .fwd_data   (FWD_RD_DATA[i*DATA_W +: DATA_W]),
            .load_hit   (load_hit[i])
        );
    end

    assign hazard = |load_hit;
    assign mask_w = rat_pipe_pkg::low_mask(cnt);

    // Next-state and Mealy control decode; a branch beats a load-use hazard
    // because the stalled instruction is squashed anyway.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        squash_c = '0;
        case (state)
            rat_pipe_pkg::RUN: begin
                if (BRN_TAKEN) begin
                    squash_c = '1;
                    bubble_c = 1'b1;
                    cnt_nx   = 3'(FLUSH_DEPTH - 1);
                    state_nx = (FLUSH_DEPTH > 1) ? rat_pipe_pkg::FLUSH : rat_pipe_pkg::RUN;
                end else if (hazard) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    state_nx = rat_pipe_pkg::STALL;
                end
            end
            rat_pipe_pkg::STALL: begin
                // Load has moved to writeback and is forwarded from there.
                state_nx = rat_pipe_pkg::RUN;
            end
            rat_pipe_pkg::FLUSH: begin
                squash_c = mask_w[FLUSH_DEPTH-1:0];
                cnt_nx   = cnt - 3'd1;
                if (cnt_nx == 3'd0) state_nx = rat_pipe_pkg::RUN;
            end
            default: state_nx = rat_pipe_pkg::RUN;
        endcase
    end

    // Controls are forced low while reset is held so they drop immediately.
    assign STALL     = stall_c  & ~RESET;
    assign BUBBLE_EX = bubble_c & ~RESET;
    assign SQUASH    = squash_c & {FLUSH_DEPTH{~RESET}};

    // State register and flush counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= rat_pipe_pkg::RUN;
            cnt   <= 3'd0;
        end else begin
            // NOTE: non-blocking assignments on all registered state so every
            // flop samples pre-edge values regardless of statement order.
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

`ifdef RAT_HAZARD_STATS_EN
    logic [rat_pipe_pkg::STATS_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating event counters: stall cycles and branches accepted in RUN.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if ((state == rat_pipe_pkg::RUN) && BRN_TAKEN && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign STALL_CNT = stall_cnt_q;
    assign FLUSH_CNT = flush_cnt_q;
`else
    assign STALL_CNT = 16'h0000;
    assign FLUSH_CNT = 16'h0000;
`endif

`ifndef SYNTHESIS
    // Squashed slots cannot resolve a branch; a branch here means the
    // surrounding pipeline failed to honour SQUASH.
    brn_in_flush_a: assert property (@(posedge CLK) disable iff (RESET)
        !((state == rat_pipe_pkg::FLUSH) && BRN_TAKEN));
`endif

endmodule

// File: tb/tb_rat_hazard_ctrl.sv
// Scoreboard bench for rat_hazard_ctrl (default parameters). Directed cases
// carry literal expectations; a random phase uses a cycle-level reference
// model. A monitor on the falling edge pops and compares.
module tb_rat_hazard_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int N_RD   = 2;
    localparam int DEPTH  = 2;
`ifdef RAT_HAZARD_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic                   CLK, RESET;
    logic [N_RD*ADDR_W-1:0] DEC_RD_ADDR;
    logic [N_RD-1:0]        DEC_RD_USE;
    logic [N_RD*DATA_W-1:0] RF_RD_DATA;
    logic                   EX_WR_EN, EX_WR_LOAD, WB_WR_EN, BRN_TAKEN;
    logic [ADDR_W-1:0]      EX_WR_ADDR, WB_WR_ADDR;
    logic [DATA_W-1:0]      EX_WR_DATA, WB_WR_DATA;
    logic [N_RD*DATA_W-1:0] FWD_RD_DATA;
    logic                   STALL, BUBBLE_EX;
    logic [DEPTH-1:0]       SQUASH;
    logic [15:0]            STALL_CNT, FLUSH_CNT;

    rat_hazard_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .FLUSH_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .DEC_RD_ADDR(DEC_RD_ADDR), .DEC_RD_USE(DEC_RD_USE), .RF_RD_DATA(RF_RD_DATA),
        .EX_WR_EN(EX_WR_EN), .EX_WR_ADDR(EX_WR_ADDR), .EX_WR_LOAD(EX_WR_LOAD),
        .EX_WR_DATA(EX_WR_DATA), .WB_WR_EN(WB_WR_EN), .WB_WR_ADDR(WB_WR_ADDR),
        .WB_WR_DATA(WB_WR_DATA), .BRN_TAKEN(BRN_TAKEN), .FWD_RD_DATA(FWD_RD_DATA),
        .STALL(STALL), .BUBBLE_EX(BUBBLE_EX), .SQUASH(SQUASH),
        .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [15:0] fwd;
        logic        stall;
        logic        bubble;
        logic [1:0]  squash;
        int          scnt;
        int          fcnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every unreset cycle with a pending expectation is compared.
    always @(negedge CLK) begin
        if (!RESET && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".fwd"},    32'(FWD_RD_DATA), 32'(e.fwd));
            check({e.name, ".stall"},  32'(STALL),       32'(e.stall));
            check({e.name, ".bubble"}, 32'(BUBBLE_EX),   32'(e.bubble));
            check({e.name, ".squash"}, 32'(SQUASH),      32'(e.squash));
            check({e.name, ".scnt"},   32'(STALL_CNT),   32'(e.scnt));
            check({e.name, ".fcnt"},   32'(FLUSH_CNT),   32'(e.fcnt));
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] use_v,
                         input logic [15:0] rf, input logic ex_en, input logic [4:0] ex_a,
                         input logic ex_ld, input logic [7:0] ex_d, input logic wb_en,
                         input logic [4:0] wb_a, input logic [7:0] wb_d, input logic brn);
        DEC_RD_ADDR = {a1, a0};
        DEC_RD_USE  = use_v;
        RF_RD_DATA  = rf;
        EX_WR_EN    = ex_en;
        EX_WR_ADDR  = ex_a;
        EX_WR_LOAD  = ex_ld;
        EX_WR_DATA  = ex_d;
        WB_WR_EN    = wb_en;
        WB_WR_ADDR  = wb_a;
        WB_WR_DATA  = wb_d;
        BRN_TAKEN   = brn;
    endtask

    task automatic expect_out(input string nm, input logic [15:0] fwd, input logic st,
                              input logic bb, input logic [1:0] sq, input int sc, input int fc);
        exp_t e;
        e.name = nm; e.fwd = fwd; e.stall = st; e.bubble = bb; e.squash = sq;
        e.scnt = STATS * sc; e.fcnt = STATS * fc;
        sb.push_back(e);
    endtask

    // Reference model state: slots still to squash, stall just taken, event totals.
    int m_flush_left, m_stalls, m_flushes;
    bit m_stall_last;

    task automatic model_step(output exp_t e);
        logic [7:0] opnd [N_RD];
        bit         haz;
        haz = 0;
        for (int i = 0; i < N_RD; i++) begin
            logic [4:0] a;
            a = DEC_RD_ADDR[i*ADDR_W +: ADDR_W];
            if (EX_WR_EN && !EX_WR_LOAD && EX_WR_ADDR == a)      opnd[i] = EX_WR_DATA;
            else if (WB_WR_EN && WB_WR_ADDR == a)                opnd[i] = WB_WR_DATA;
            else                                                 opnd[i] = RF_RD_DATA[i*DATA_W +: DATA_W];
            if (DEC_RD_USE[i] && EX_WR_EN && EX_WR_LOAD && EX_WR_ADDR == a) haz = 1;
        end
        e.name = "rand"; e.fwd = {opnd[1], opnd[0]};
        e.stall = 0; e.bubble = 0; e.squash = 0;
        e.scnt = STATS * m_stalls; e.fcnt = STATS * m_flushes;
        if (m_flush_left > 0) begin
            e.squash = 2'((1 << m_flush_left) - 1);
            m_flush_left--;
        end else if (m_stall_last) begin
            m_stall_last = 0;
        end else if (BRN_TAKEN) begin
            e.squash = 2'((1 << DEPTH) - 1);
            e.bubble = 1;
            m_flush_left = DEPTH - 1;
            m_flushes++;
        end else if (haz) begin
            e.stall = 1; e.bubble = 1;
            m_stall_last = 1;
            m_stalls++;
        end
    endtask

    initial begin
        RESET = 1'b1;
        drive(0, 0, 2'b00, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge CLK);
        #1;
        check("reset.stall",  32'(STALL),     32'h0);
        check("reset.bubble", 32'(BUBBLE_EX), 32'h0);
        check("reset.squash", 32'(SQUASH),    32'h0);
        check("reset.scnt",   32'(STALL_CNT), 32'h0);

        // 1: EX forward to port 0; port 1 reads RF.
        next_cycle(); RESET = 1'b0;
        drive(3, 7, 2'b01, 16'hEEDD, 1, 3, 0, 8'h5A, 0, 0, 8'h00, 0);
        expect_out("t1_ex_fwd", 16'hEE5A, 0, 0, 2'b00, 0, 0);
        // 2: EX beats WB on both ports; WB alone; EX load does not forward.
        next_cycle(); drive(3, 3, 2'b11, 16'hEEDD, 1, 3, 0, 8'h11, 1, 3, 8'h22, 0);
        expect_out("t2_ex_prio", 16'h1111, 0, 0, 2'b00, 0, 0);
        next_cycle(); drive(3, 3, 2'b11, 16'hEEDD, 0, 3, 0, 8'h11, 1, 3, 8'h22, 0);
        expect_out("t2_wb_only", 16'h2222, 0, 0, 2'b00, 0, 0);
        next_cycle(); drive(3, 3, 2'b00, 16'hEEDD, 1, 3, 1, 8'h11, 1, 3, 8'h22, 0);
        expect_out("t2_load_nofwd", 16'h2222, 0, 0, 2'b00, 0, 0);
        // 3: load-use on port 1, then load forwarded from WB.
        next_cycle(); drive(0, 4, 2'b10, 16'hEEDD, 1, 4, 1, 8'h99, 0, 0, 8'h00, 0);
        expect_out("t3_stall", 16'hEEDD, 1, 1, 2'b00, 0, 0);
        next_cycle(); drive(0, 4, 2'b10, 16'hEEDD, 0, 0, 0, 8'h00, 1, 4, 8'hC3, 0);
        expect_out("t3_wb_fwd", 16'hC3DD, 0, 0, 2'b00, 1, 0);
        next_cycle(); drive(0, 4, 2'b10, 16'hEEDD, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        expect_out("t3_run", 16'hEEDD, 0, 0, 2'b00, 1, 0);
        // 4: taken branch flush sequence.
        next_cycle(); BRN_TAKEN = 1'b1;
        expect_out("t4_brn", 16'hEEDD, 0, 1, 2'b11, 1, 0);
        next_cycle(); BRN_TAKEN = 1'b0;
        expect_out("t4_flush", 16'hEEDD, 0, 0, 2'b01, 1, 1);
        next_cycle();
        expect_out("t4_done", 16'hEEDD, 0, 0, 2'b00, 1, 1);
        // 5: branch and load-use together: branch wins.
        next_cycle(); drive(0, 4, 2'b10, 16'hEEDD, 1, 4, 1, 8'h99, 0, 0, 8'h00, 1);
        expect_out("t5_brn_haz", 16'hEEDD, 0, 1, 2'b11, 1, 1);
        next_cycle(); drive(0, 4, 2'b10, 16'hEEDD, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        expect_out("t5_flush", 16'hEEDD, 0, 0, 2'b01, 1, 2);
        // 6: reset mid-flush drops SQUASH asynchronously and clears counters.
        next_cycle(); BRN_TAKEN = 1'b1;
        expect_out("t6_brn", 16'hEEDD, 0, 1, 2'b11, 1, 2);
        next_cycle(); BRN_TAKEN = 1'b0;
        check("t6_pre_squash", 32'(SQUASH), 32'h1);
        RESET = 1'b1;
        #1;
        check("t6_async_squash", 32'(SQUASH),    32'h0);
        check("t6_async_scnt",   32'(STALL_CNT), 32'h0);
        check("t6_async_fcnt",   32'(FLUSH_CNT), 32'h0);
        drive(0, 4, 2'b10, 16'hEEDD, 1, 4, 1, 8'h99, 0, 0, 8'h00, 0);
        #1;
        check("t6_rst_stall",  32'(STALL),     32'h0);
        check("t6_rst_bubble", 32'(BUBBLE_EX), 32'h0);
        next_cycle(); RESET = 1'b0;
        drive(0, 4, 2'b00, 16'hEEDD, 1, 4, 1, 8'h99, 0, 0, 8'h00, 0);
        expect_out("t6_use_blocks", 16'hEEDD, 0, 0, 2'b00, 0, 0);
        next_cycle(); DEC_RD_USE = 2'b10;
        expect_out("t6_run_stall", 16'hEEDD, 1, 1, 2'b00, 0, 0);
        next_cycle(); drive(0, 4, 2'b10, 16'hEEDD, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        expect_out("t6_after", 16'hEEDD, 0, 0, 2'b00, 1, 0);

        // Random phase from a fresh reset against the reference model.
        next_cycle(); RESET = 1'b1;
        drive(0, 0, 2'b00, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_flush_left = 0; m_stalls = 0; m_flushes = 0; m_stall_last = 0;
        next_cycle(); RESET = 1'b0;
        for (int c = 0; c < 400; c++) begin
            exp_t e;
            bit   brn_ok;
            brn_ok = (m_flush_left == 0) && !m_stall_last;
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom),
                  16'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom),
                  5'($urandom_range(0, 7)), 8'($urandom),
                  brn_ok && ($urandom_range(0, 7) == 0));
            model_step(e);
            sb.push_back(e);
            next_cycle();
        end
        drive(0, 0, 2'b00, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
